// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// operation and FSM state encodings, iteration count, and op decode helpers.
package muldiv_pkg;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   acc_i   : accumulator {hi, lo}. Multiply: {partial product, remaining
//             multiplier bits}. Divide: {partial remainder, dividend/quotient}.
//   opnd_i  : multiplicand (multiply) or divisor (divide), as a magnitude
//   op_i    : operation; only multiply vs. divide matters here
//   acc_o   : next accumulator; for divide the LSB is left 0
//   q_bit_o : quotient bit produced this iteration (0 for multiply)
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  op_e                op_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    acc_o   = acc_i;
    q_bit_o = 1'b0;
    if (op_is_div(op_i)) begin
      // Restoring step: shift the next dividend bit into the remainder,
      // try a 33-bit subtract; no borrow means the quotient bit is 1.
      shifted = acc_i[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, opnd_i};
      q_bit_o = ~diff[WIDTH];
      acc_o   = {(q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                 acc_i[WIDTH-2:0], 1'b0};
    end else begin
      // Shift-add, LSB first: the multiplier lives in the low half and is
      // consumed as the product shifts down into it.
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
            + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit (MULT/MULTU/DIV/DIVU).
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start, op  : issue request (sampled in IDLE) and operation
//   a, b       : rs / rt operands, latched at start
//   flush      : cancels any in-flight operation, no done
//   busy       : high whenever not IDLE
//   done       : one-cycle completion pulse
//   result     : {hi, lo}, held until the next completion
module ex_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = muldiv_pkg::ITER
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  import muldiv_pkg::*;

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  op_e                op_in;
  logic               a_neg, b_neg, div0;
  logic [WIDTH-1:0]   mag_a, mag_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .op_i    (op_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    result_d = result_q;

    op_in = op_e'(op);
    a_neg = op_is_signed(op_in) & a[WIDTH-1];
    b_neg = op_is_signed(op_in) & b[WIDTH-1];
    div0  = (b == '0);
    // |0x80000000| wraps back to 0x80000000, which is correct as unsigned.
    mag_a = a_neg ? (-a) : a;
    mag_b = b_neg ? (-b) : b;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          op_d    = op_in;
          cnt_d   = '0;
          if (op_is_div(op_in)) begin
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            opnd_d   = mag_b;
            // Divide by zero yields all-ones quotient and the dividend as
            // remainder; keeping the quotient un-negated and negating the
            // remainder magnitude for a negative dividend gives hi = a.
            neg_lo_d = (a_neg ^ b_neg) & ~div0;
            neg_hi_d = a_neg;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, mag_b};
            opnd_d   = mag_a;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = 1'b0;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_is_div(op_q)) begin
          result_d = {(neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]),
                      (neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0])};
        end else begin
          result_d = neg_lo_q ? -acc_q : acc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything, including a start in IDLE.
    if (flush) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed table, randomized ops against
// an arithmetic reference model, and flush / ignored-start / async-reset cases.
module tb_ex_muldiv;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           flush;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  ex_muldiv #(.WIDTH(W), .ITER(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder takes the dividend's sign, matching MIPS semantics.
  function automatic logic [63:0] ref_muldiv(input logic [1:0] o,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, rm;
    logic [63:0] r;
    sx = $signed(x);
    sy = $signed(y);
    r  = '0;
    case (o)
      2'b00: r = 64'(sx * sy);
      2'b01: r = {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) r = {x, 32'hFFFFFFFF};
        else begin
          q  = sx / sy;
          rm = sx % sy;
          r  = {rm[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  // Caller is at a negedge with the unit idle. Returns the result seen with
  // done, the number of edges after the start edge until done, and the number
  // of sampled cycles with busy high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] r, output int edges, output int busy_n);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a  = $urandom;
    b  = $urandom;
    edges  = -1;
    busy_n = 0;
    r      = '0;
    if (busy) busy_n++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        edges = k;
        r     = result;
        break;
      end
    end
  endtask

  initial begin
    vec_t        tbl [10];
    logic [63:0] r;
    logic [63:0] prev;
    int          e, bn, dn;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;

    tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
    tbl[2] = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tbl[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
    tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    tbl[5] = '{2'b11, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF};
    tbl[6] = '{2'b11, 32'd100,      32'd7,        64'h00000002_0000000E};
    tbl[7] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    tbl[8] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF};
    tbl[9] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};

    repeat (3) @(negedge clk);
    check("reset_busy",   64'(busy), 64'd0);
    check("reset_done",   64'(done), 64'd0);
    check("reset_result", result,    64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, e, bn);
      check($sformatf("tbl%0d_result", i),  r,       tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), 64'(e),  64'd33);
      check($sformatf("tbl%0d_busy", i),    64'(bn), 64'd33);
      @(negedge clk);
      check($sformatf("tbl%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // Random ops, issued back-to-back (start while done is high).
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      run_op(o, x, y, r, e, bn);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, o, x, y), r, ref_muldiv(o, x, y));
      check($sformatf("rnd%0d_latency", i), 64'(e), 64'd33);
    end

    // start while busy is ignored: exactly one done, from the first op.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1234; b = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    r  = '0;
    repeat (80) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (dn == 1) r = result;
      end
    end
    check("busy_start_done_count", 64'(dn), 64'd1);
    check("busy_start_result",     r,       64'd1234 * 64'd5678);
    prev = 64'd1234 * 64'd5678;

    // Flush about 10 cycles into a MULT.
    start = 1'b1; op = 2'b00; a = 32'h00012345; b = 32'h00000777;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    dn = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("flush_no_done",      64'(dn), 64'd0);
    check("flush_result_held",  result,  prev);

    // flush together with start in IDLE: nothing starts.
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("flush_start_no_done", 64'(dn), 64'd0);
    check("flush_start_result",  result,  prev);

    // Asynchronous reset between edges during CALC.
    start = 1'b1; op = 2'b11; a = 32'hFFFFFFF0; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy",   64'(busy), 64'd0);
    check("async_reset_done",   64'(done), 64'd0);
    check("async_reset_result", result,    64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("async_reset_no_done", 64'(dn), 64'd0);
    run_op(2'b11, 32'd100, 32'd7, r, e, bn);
    check("post_reset_divu",    r,      64'h00000002_0000000E);
    check("post_reset_latency", 64'(e), 64'd33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
